// File: rtl/ctrl_pkg.sv
// Shared types and constants for the I2S sequencing controller.
//   frame_size_t : bits per channel selector (16 or 32)
//   state_t      : controller FSM states
//   BITS16_LAST / BITS32_LAST : reload values of the per-channel bit counter
package ctrl_pkg;

    typedef enum logic {
        f16bits = 1'b0,
        f32bits = 1'b1
    } frame_size_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PREFILL = 2'd1,
        RUN     = 2'd2,
        DRAIN   = 2'd3
    } state_t;

    localparam logic [4:0] BITS16_LAST = 5'd15;
    localparam logic [4:0] BITS32_LAST = 5'd31;

    // Bit-counter reload value (index of the last bit in a channel).
    function automatic logic [4:0] last_bit(input frame_size_t fs);
        return (fs == f32bits) ? BITS32_LAST : BITS16_LAST;
    endfunction

endpackage

// File: rtl/sck_gen.sv
// SCK generator: programmable divider plus registered bit clock.
//   pclk, rst_   : system clock, asynchronous active-low reset
//   run_i        : 1 = count and toggle; 0 = hold divider and sck at 0
//   clk_div_i    : SCK half-period in pclk cycles, minus 1
//   sck_o        : registered serial bit clock
//   rise_o       : high in the cycle whose edge takes sck 0->1
//   fall_o       : high in the cycle whose edge takes sck 1->0
module sck_gen (
    input  logic       pclk,
    input  logic       rst_,
    input  logic       run_i,
    input  logic [7:0] clk_div_i,
    output logic       sck_o,
    output logic       rise_o,
    output logic       fall_o
);

    logic [7:0] div_q, div_d;
    logic       sck_q, sck_d;
    logic       wrap;

    // Wrap only on an exact match: if clk_div shrinks below the current
    // count, the counter runs on and rolls over through 8'hFF -> 0.
    always_comb begin
        wrap  = run_i && (div_q == clk_div_i);
        div_d = div_q;
        sck_d = sck_q;
        if (!run_i) begin
            div_d = '0;
            sck_d = 1'b0;
        end else if (wrap) begin
            div_d = '0;
            sck_d = ~sck_q;
        end else begin
            div_d = div_q + 8'd1;
        end
    end

    always_ff @(posedge pclk or negedge rst_) begin
        if (!rst_) begin
            div_q <= '0;
            sck_q <= 1'b0;
        end else begin
            div_q <= div_d;
            sck_q <= sck_d;
        end
    end

    assign sck_o  = sck_q;
    assign rise_o = wrap & ~sck_q;
    assign fall_o = wrap &  sck_q;

endmodule

// File: rtl/i2s_seq_ctrl.sv
// I2S master sequencing controller: generates SCK/WS, paces the TX/RX FIFOs
// one bit per SCK edge and flags FIFO underrun/overrun.
//   pclk, rst_          : system clock, asynchronous active-low reset
//   en                  : run request; 0 stops at the end of the right channel
//   frame_size          : bits per channel, latched when leaving IDLE
//   clk_div             : SCK half-period in pclk cycles, minus 1
//   tx_empty, rx_full   : FIFO status flags
//   clr_err             : pulse, clears underrun/overrun
//   sck, ws             : registered I2S bit clock and word select
//   tx_read, rx_write   : one-cycle FIFO strobes, aligned with the sck change
//   underrun, overrun   : sticky error flags
//   busy                : controller not in IDLE
module i2s_seq_ctrl
    import ctrl_pkg::*;
(
    input  logic        pclk,
    input  logic        rst_,
    input  logic        en,
    input  frame_size_t frame_size,
    input  logic [7:0]  clk_div,
    input  logic        tx_empty,
    input  logic        rx_full,
    input  logic        clr_err,
    output logic        sck,
    output logic        ws,
    output logic        tx_read,
    output logic        rx_write,
    output logic        underrun,
    output logic        overrun,
    output logic        busy
);

    state_t      state_q;
    frame_size_t fs_q;
    logic [4:0]  bitcnt_q;
    logic        ws_q;
    logic        tx_read_q, rx_write_q;
    logic        underrun_q, overrun_q;
    logic        busy_q;

    logic        run;
    logic        rise, fall;

    assign run = (state_q == RUN) || (state_q == DRAIN);

    sck_gen u_sck_gen (
        .pclk      (pclk),
        .rst_      (rst_),
        .run_i     (run),
        .clk_div_i (clk_div),
        .sck_o     (sck),
        .rise_o    (rise),
        .fall_o    (fall)
    );

    always_ff @(posedge pclk or negedge rst_) begin
        if (!rst_) begin
            state_q    <= IDLE;
            fs_q       <= f16bits;
            bitcnt_q   <= '0;
            ws_q       <= 1'b0;
            tx_read_q  <= 1'b0;
            rx_write_q <= 1'b0;
            underrun_q <= 1'b0;
            overrun_q  <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            // Strobes and flags change on the same edge as sck; events only
            // exist while the divider runs, i.e. in RUN or DRAIN.
            tx_read_q  <= fall & ~tx_empty;
            rx_write_q <= rise & ~rx_full;
            underrun_q <= (fall & tx_empty) | (underrun_q & ~clr_err);
            overrun_q  <= (rise & rx_full)  | (overrun_q  & ~clr_err);

            case (state_q)
                IDLE: begin
                    if (en) begin
                        state_q <= PREFILL;
                        fs_q    <= frame_size;
                        busy_q  <= 1'b1;
                    end
                end
                PREFILL: begin
                    if (!en) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else if (!tx_empty) begin
                        state_q  <= RUN;
                        bitcnt_q <= last_bit(fs_q);
                        ws_q     <= 1'b0;
                    end
                end
                RUN, DRAIN: begin
                    if (fall) begin
                        if (bitcnt_q == '0) begin
                            bitcnt_q <= last_bit(fs_q);
                            ws_q     <= ~ws_q;
                        end else begin
                            bitcnt_q <= bitcnt_q - 5'd1;
                        end
                    end
                    if (state_q == RUN) begin
                        if (!en) state_q <= DRAIN;
                    end else if (en) begin
                        state_q <= RUN;
                    end else if (fall && (bitcnt_q == '0) && ws_q) begin
                        // End of right channel: sck falls on this edge anyway.
                        state_q  <= IDLE;
                        busy_q   <= 1'b0;
                        ws_q     <= 1'b0;
                        bitcnt_q <= '0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign ws       = ws_q;
    assign tx_read  = tx_read_q;
    assign rx_write = rx_write_q;
    assign underrun = underrun_q;
    assign overrun  = overrun_q;
    assign busy     = busy_q;

endmodule
